pipe_mux_n: RTL
===============

// Module: pipe_mux_n
// PURPOSE
//   Parametrised N-input, WIDTH-bit selector with a configurable registered pipeline behind it.
//   Used in the pipelined datapath wherever a source select feeds a pipeline boundary,
//   e.g. forwarding-operand select into ID/EX and writeback-source select into MEM/WB.
//   Carries a valid bit per stage and obeys the global stall/flush controls, so hazard logic drives it directly.
// PARAMETERS
//   WIDTH   32  data width of each input and of the output
//   N_IN    4   number of data inputs (2..16, need not be a power of 2)
//   STAGES  1   register stages after the select (1..4); latency in cycles
//   SEL_W   $clog2(N_IN)  select width; derived, never overridden
// PORTS
//   clk        in   1             rising-edge clock
//   rst        in   1             synchronous reset, active-high
//   in_data    in   N_IN*WIDTH    packed inputs; input k = in_data[k*WIDTH +: WIDTH]
//   sel        in   SEL_W         binary select, sampled with in_valid
//   in_valid   in   1             qualifies in_data/sel this cycle
//   stall      in   1             hold every stage (global pipeline stall)
//   flush      in   1             invalidate every stage (branch/exception squash)
//   out_data   out  WIDTH         last-stage data
//   out_valid  out  1             last-stage valid
//   out_sel    out  SEL_W         select value that produced out_data (travels with data)
// BEHAVIOUR
//   - Reset (rst=1 at posedge): all stage data, sel and valid regs -> 0; out_data=0, out_valid=0, out_sel=0.
//   - Select: comb mux_d = input[sel] if sel < N_IN, else all-zero; evaluated every cycle.
//   - Stage 1 loads {mux_d, sel, in_valid}; stage i loads stage i-1; out_* = stage STAGES.
//   - Latency: exactly STAGES cycles from in_valid sample to out_valid, absent stall.
//   - Data/sel regs load regardless of valid (no enable gating beyond stall); valid alone qualifies them.
//   - Priority per cycle: rst > flush > stall > advance.
//   - flush=1: all valid regs -> 0 next edge; data/sel regs load normally (stall ignored). Input of
//     that cycle is also dropped.
//   - stall=1 (flush=0): every data, sel and valid reg holds; input of that cycle is dropped; upstream
//     holds its own values.
//   - stall and flush together: flush wins, pipeline advances with valids cleared.
//   - rst mid-operation: in-flight entries discarded, no partial output; first valid out STAGES cycles
//     after the first post-reset in_valid.
//   - No backpressure handshake: out_valid is a one-cycle pulse per entry unless stall holds it.
// CONFIGURATION
//   Macro PIPE_MUX_SEL_CHECK_EN:
//   - defined: adds output sel_err (1 bit, reset 0). Flag is sticky: set at the edge where
//     in_valid=1, stall=0, flush=0 and sel >= N_IN. Cleared only by rst. Out-of-range data still
//     forced to zero.
//   - undefined: no sel_err port, no check logic; out-of-range select silently yields zero.
//   - With N_IN a power of 2, the check is constant-false when defined; sel_err stays 0.
// STRUCTURE
//   - Shared package pipe_mux_pkg: MAX_STAGES=4, MAX_N_IN=16 and a sel_in_range(sel, n) function.
//     The same package is used by the forwarding unit.
//   - One sub-module pipe_stage_reg #(WIDTH, SEL_W): single stage of {data, sel, valid} with
//     stall/flush/rst. Instantiated STAGES times in a generate loop.
//   - The comb select stays in pipe_mux_n as a for-loop compare against sel.
// TESTING
//   1. N_IN=4,STAGES=1: in_data={D3..D0}={0xDDDD,0xCCCC,0xBBBB,0xAAAA}, sel=2, in_valid=1 ->
//      next cycle out_data=0xCCCC, out_valid=1, out_sel=2.
//   2. STAGES=3, stream sel=0,1,2,3 on four cycles -> outputs 0xAAAA..0xDDDD on cycles 3..6,
//      back-to-back, in order.
//   3. STAGES=2: stall=1 for 2 cycles with one entry in flight -> out_valid/out_data frozen, entry
//      appears exactly 2 cycles late. Input presented during stall is not emitted.
//   4. Two entries in flight, flush=1 together with stall=1 for 1 cycle -> out_valid stays 0 for
//      next STAGES cycles; the next valid input emerges with normal latency.
//   5. N_IN=5, sel=6, in_valid=1 -> out_data=0, out_valid=1; with PIPE_MUX_SEL_CHECK_EN,
//      sel_err=1 and holds after sel returns in range.
//   6. rst=1 mid-stream for 1 cycle -> all outputs 0 next edge; no pre-reset entry ever emerges.

Source files
------------

// File: rtl/pipe_mux_pkg.sv
// Shared constants and helpers for pipe_mux_n and the forwarding unit.
package pipe_mux_pkg;

  localparam int MAX_STAGES = 4;
  localparam int MAX_N_IN   = 16;

  function automatic logic sel_in_range(input int unsigned sel, input int unsigned n);
    return sel < n;
  endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline stage of {data, sel, valid}; priority rst > flush > stall > advance.
module pipe_stage_reg #(
  parameter int WIDTH = 32,
  parameter int SEL_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [SEL_W-1:0] sel_i,
  input  logic             valid_i,
  output logic [WIDTH-1:0] data_o,
  output logic [SEL_W-1:0] sel_o,
  output logic             valid_o
);

  logic [WIDTH-1:0] data_q, data_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             valid_q, valid_d;

  // Flush overrides stall: the stage still advances, only the valid bit is dropped.
  always_comb begin
    data_d  = data_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    if (flush_i) begin
      data_d  = data_i;
      sel_d   = sel_i;
      valid_d = 1'b0;
    end else if (!stall_i) begin
      data_d  = data_i;
      sel_d   = sel_i;
      valid_d = valid_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign sel_o   = sel_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/pipe_mux_n.sv
// N-input selector feeding STAGES pipeline registers with stall/flush.
// Optional PIPE_MUX_SEL_CHECK_EN adds a sticky sel_err flag for out-of-range selects.
module pipe_mux_n
  import pipe_mux_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int N_IN   = 4,
  parameter int STAGES = 1,
  localparam int SEL_W = $clog2(N_IN)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  in_valid,
  input  logic                  stall,
  input  logic                  flush,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  output logic [SEL_W-1:0]      out_sel
`ifdef PIPE_MUX_SEL_CHECK_EN
  ,
  output logic                  sel_err
`endif
);

  if (STAGES < 1 || STAGES > MAX_STAGES || N_IN < 2 || N_IN > MAX_N_IN) begin : g_bad_cfg
    $error("pipe_mux_n: unsupported STAGES/N_IN");
  end

  logic [WIDTH-1:0] mux_d;

  // Unmatched (out-of-range) select leaves the default zero.
  always_comb begin
    mux_d = '0;
    for (int k = 0; k < N_IN; k++) begin
      if (sel == SEL_W'(k)) mux_d = in_data[k*WIDTH +: WIDTH];
    end
  end

  logic [STAGES:0][WIDTH-1:0] data_pipe;
  logic [STAGES:0][SEL_W-1:0] sel_pipe;
  logic [STAGES:0]            vld_pipe;

  assign data_pipe[0] = mux_d;
  assign sel_pipe[0]  = sel;
  assign vld_pipe[0]  = in_valid;

  for (genvar i = 1; i <= STAGES; i++) begin : g_stage
    pipe_stage_reg #(
      .WIDTH (WIDTH),
      .SEL_W (SEL_W)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .stall_i (stall),
      .flush_i (flush),
      .data_i  (data_pipe[i-1]),
      .sel_i   (sel_pipe[i-1]),
      .valid_i (vld_pipe[i-1]),
      .data_o  (data_pipe[i]),
      .sel_o   (sel_pipe[i]),
      .valid_o (vld_pipe[i])
    );
  end

  assign out_data  = data_pipe[STAGES];
  assign out_sel   = sel_pipe[STAGES];
  assign out_valid = vld_pipe[STAGES];

`ifdef PIPE_MUX_SEL_CHECK_EN
  logic sel_err_q, sel_err_d;

  // Only selects actually accepted into the pipeline can raise the flag.
  always_comb begin
    sel_err_d = sel_err_q;
    if (in_valid && !stall && !flush && !sel_in_range(32'(sel), N_IN)) sel_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) sel_err_q <= 1'b0;
    else     sel_err_q <= sel_err_d;
  end

  assign sel_err = sel_err_q;
`endif

endmodule
